// File: rtl/pjw_stream_hash.sv
// PJW (ELF-style) streaming hash.
// Accepts one word in IDLE and hashes its byte lanes one per cycle, MSB lane first.
// The accumulator is carried across words until a word marked Last completes
// the message. The hash and the kept-byte count are then held until OutReady.
module pjw_stream_hash #(
    parameter int BYTES_PER_WORD = 4,
    parameter int HASH_W         = 32,
    parameter int LEN_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        Valid,
    output logic                        Ready,
    input  logic [8*BYTES_PER_WORD-1:0] DataIn,
    input  logic [BYTES_PER_WORD-1:0]   Keep,
    input  logic                        Last,
    input  logic                        Clear,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [HASH_W-1:0]           DataOut,
    output logic [LEN_W-1:0]            MsgLen
);

    localparam int E       = HASH_W / 8;
    localparam int FOLD_SH = (3 * HASH_W) / 4;
    localparam int LANE_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [HASH_W-1:0] TOP_MASK = {{E{1'b1}}, {(HASH_W-E){1'b0}}};

    typedef enum logic [1:0] {IDLE, HASH, OUT} state_t;

    state_t                      state_q, state_d;
    logic [HASH_W-1:0]           acc_q, acc_d;
    logic [LEN_W-1:0]            cnt_q, cnt_d;
    logic [LANE_W-1:0]           lane_q, lane_d;
    logic [8*BYTES_PER_WORD-1:0] data_q, data_d;
    logic [BYTES_PER_WORD-1:0]   keep_q, keep_d;
    logic                        last_q, last_d;
    logic [HASH_W-1:0]           dout_q, dout_d;

    logic [7:0]                  lane_byte;
    logic                        lane_keep;
    logic [HASH_W-1:0]           shl, fold_x, folded, hashed;

    // Select the byte and keep bit of the lane currently being hashed.
    always_comb begin
        lane_byte = '0;
        lane_keep = 1'b0;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (lane_q == LANE_W'(i)) begin
                lane_byte = data_q[8*i +: 8];
                lane_keep = keep_q[i];
            end
        end
    end

    // One PJW step: shift in the byte, fold the top E bits back down, clear them.
    always_comb begin
        shl    = {acc_q[HASH_W-E-1:0], {E{1'b0}}} + {{(HASH_W-8){1'b0}}, lane_byte};
        fold_x = shl & TOP_MASK;
        folded = (fold_x != '0) ? (shl ^ (fold_x >> FOLD_SH)) : shl;
        hashed = folded & ~fold_x;
    end

    // Next-state and datapath next values; Clear wins over Valid, and is ignored in OUT.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (Clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (Valid) begin
                    data_d  = DataIn;
                    keep_d  = Keep;
                    last_d  = Last;
                    lane_d  = LANE_W'(BYTES_PER_WORD - 1);
                    state_d = HASH;
                end
            end
            HASH: begin
                if (Clear) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    if (lane_keep) begin
                        acc_d = hashed;
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
                    end
                    if (lane_q == '0) begin
                        if (last_q) begin
                            dout_d  = acc_d;
                            state_d = OUT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        lane_d = lane_q - LANE_W'(1);
                    end
                end
            end
            OUT: begin
                if (OutReady) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            lane_q <= '0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            dout_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            lane_q <= lane_d;
            data_q <= data_d;
            keep_q <= keep_d;
            last_q <= last_d;
            dout_q <= dout_d;
        end
    end

    assign Ready    = (state_q == IDLE);
    assign OutValid = (state_q == OUT);
    assign DataOut  = dout_q;
    assign MsgLen   = cnt_q;

endmodule

// File: tb/tb_pjw_stream_hash.sv
// Directed bench for pjw_stream_hash: default 4-byte/32-bit instance, a
// LEN_W=2 instance sharing its inputs for counter saturation, and a
// 1-byte/64-bit instance for the parameter sweep.
module tb_pjw_stream_hash;

    logic        clk = 1'b0;
    logic        rst;
    logic        Valid, Last, Clear, OutReady;
    logic [31:0] DataIn;
    logic [3:0]  Keep;
    logic        Ready, OutValid;
    logic [31:0] DataOut;
    logic [15:0] MsgLen;

    logic        ready_s, outvalid_s;
    logic [31:0] dataout_s;
    logic [1:0]  msglen_s;

    logic        v64, l64, c64, or64, ready64, outvalid64;
    logic [7:0]  d64;
    logic [0:0]  k64;
    logic [63:0] dataout64;
    logic [15:0] msglen64;

    int checks = 0;
    int errors = 0;

    pjw_stream_hash #(.BYTES_PER_WORD(4), .HASH_W(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .Valid(Valid), .Ready(Ready), .DataIn(DataIn),
        .Keep(Keep), .Last(Last), .Clear(Clear), .OutValid(OutValid),
        .OutReady(OutReady), .DataOut(DataOut), .MsgLen(MsgLen)
    );

    pjw_stream_hash #(.BYTES_PER_WORD(4), .HASH_W(32), .LEN_W(2)) dut_sat (
        .clk(clk), .rst(rst), .Valid(Valid), .Ready(ready_s), .DataIn(DataIn),
        .Keep(Keep), .Last(Last), .Clear(Clear), .OutValid(outvalid_s),
        .OutReady(OutReady), .DataOut(dataout_s), .MsgLen(msglen_s)
    );

    pjw_stream_hash #(.BYTES_PER_WORD(1), .HASH_W(64), .LEN_W(16)) dut64 (
        .clk(clk), .rst(rst), .Valid(v64), .Ready(ready64), .DataIn(d64),
        .Keep(k64), .Last(l64), .Clear(c64), .OutValid(outvalid64),
        .OutReady(or64), .DataOut(dataout64), .MsgLen(msglen64)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !Ready; i++) step();
        check("ready_wait", Ready, 1);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 20 && !OutValid; i++) step();
        check("outvalid_wait", OutValid, 1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        wait_ready();
        DataIn = d;
        Keep   = k;
        Last   = l;
        Valid  = 1'b1;
        step();
        Valid  = 1'b0;
        check("accepted", Ready, 0);
    endtask

    // After acceptance: OutValid low for three more edges, high after the fourth.
    task automatic latency_check(input string tag);
        for (int i = 0; i < 3; i++) begin
            step();
            check({tag, "_early"}, OutValid, 0);
        end
        step();
        check({tag, "_outvalid"}, OutValid, 1);
    endtask

    task automatic handshake(input logic [31:0] last_out);
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        check("hs_ready", Ready, 1);
        check("hs_outvalid", OutValid, 0);
        check("hs_msglen", MsgLen, 0);
        check("hs_dataout_kept", DataOut, last_out);
    endtask

    initial begin
        rst = 1'b1; Valid = 1'b0; Last = 1'b0; Clear = 1'b0; OutReady = 1'b0;
        DataIn = '0; Keep = '0;
        v64 = 1'b0; l64 = 1'b0; c64 = 1'b0; or64 = 1'b0; d64 = '0; k64 = '0;

        // Reset state
        step();
        step();
        check("rst_ready", Ready, 1);
        check("rst_outvalid", OutValid, 0);
        check("rst_dataout", DataOut, 0);
        check("rst_msglen", MsgLen, 0);
        rst = 1'b0;
        step();

        // Single word
        send_word(32'h0000_0041, 4'b1111, 1'b1);
        latency_check("single");
        check("single_data", DataOut, 32'h0000_0041);
        check("single_len", MsgLen, 4);
        handshake(32'h0000_0041);

        // Multi-word with fold
        send_word(32'hFFFF_FFFF, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("mw_busy", Ready, 0);
        step();
        check("mw_ready_between", Ready, 1);
        check("mw_no_out", OutValid, 0);
        send_word(32'hFFFF_FF00, 4'b1110, 1'b1);
        wait_out();
        check("mw_data", DataOut, 32'h0000_00FF);
        check("mw_len", MsgLen, 7);
        handshake(32'h0000_00FF);

        // Skipped lanes
        send_word(32'h4100_4200, 4'b1010, 1'b1);
        latency_check("skip");
        check("skip_data", DataOut, 32'h0000_0452);
        check("skip_len", MsgLen, 2);

        // Backpressure, with Clear/Valid driven while in OUT
        Clear = 1'b1;
        Valid = 1'b1;
        DataIn = 32'h1111_1111;
        Keep = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            check("bp_outvalid", OutValid, 1);
            check("bp_ready", Ready, 0);
            check("bp_data", DataOut, 32'h0000_0452);
            check("bp_len", MsgLen, 2);
        end
        Clear = 1'b0;
        Valid = 1'b0;
        handshake(32'h0000_0452);

        // Empty message
        send_word(32'hDEAD_BEEF, 4'b0000, 1'b1);
        latency_check("empty");
        check("empty_data", DataOut, 0);
        check("empty_len", MsgLen, 0);
        handshake(32'h0);

        // Clear during second HASH cycle
        send_word(32'h1234_5678, 4'b1111, 1'b1);
        step();
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        check("clr_ready", Ready, 1);
        check("clr_len", MsgLen, 0);
        send_word(32'h0000_0041, 4'b1111, 1'b1);
        wait_out();
        check("clr_data", DataOut, 32'h0000_0041);
        check("clr_msglen", MsgLen, 4);
        handshake(32'h0000_0041);

        // Clear in IDLE drops a retained accumulator and beats Valid
        send_word(32'h0000_00FF, 4'b1111, 1'b0);
        wait_ready();
        DataIn = 32'h0000_0077; Keep = 4'b1111; Last = 1'b1;
        Valid = 1'b1;
        Clear = 1'b1;
        step();
        Valid = 1'b0;
        Clear = 1'b0;
        check("clr_prio_ready", Ready, 1);
        check("clr_idle_len", MsgLen, 0);
        send_word(32'h0000_0041, 4'b1111, 1'b1);
        wait_out();
        check("clr_idle_data", DataOut, 32'h0000_0041);
        check("clr_idle_len2", MsgLen, 4);
        handshake(32'h0000_0041);

        // Counter saturation on the LEN_W=2 instance
        send_word(32'h0102_0304, 4'b1111, 1'b0);
        send_word(32'h0000_0005, 4'b0001, 1'b1);
        wait_out();
        check("sat_data", DataOut, 32'h0001_2345);
        check("sat_len_wide", MsgLen, 5);
        check("sat_data_narrow", dataout_s, 32'h0001_2345);
        check("sat_len_narrow", msglen_s, 3);
        check("sat_outvalid_narrow", outvalid_s, 1);
        handshake(32'h0001_2345);
        check("sat_ready_narrow", ready_s, 1);

        // Reset mid-HASH
        send_word(32'h0000_0041, 4'b1111, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstm_ready", Ready, 1);
        check("rstm_outvalid", OutValid, 0);
        check("rstm_len", MsgLen, 0);
        check("rstm_data", DataOut, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rstm_no_out", OutValid, 0);
        end

        // Parameter sweep: 1 byte per word, 64-bit hash
        check("p64_ready0", ready64, 1);
        d64 = 8'h41; k64 = 1'b1; l64 = 1'b0; v64 = 1'b1;
        step();
        v64 = 1'b0;
        check("p64_busy", ready64, 0);
        step();
        check("p64_ready1", ready64, 1);
        d64 = 8'h42; l64 = 1'b1; v64 = 1'b1;
        step();
        v64 = 1'b0;
        step();
        check("p64_outvalid", outvalid64, 1);
        check("p64_data", dataout64, 64'h0000_0000_0000_4142);
        check("p64_len", msglen64, 2);
        or64 = 1'b1;
        step();
        or64 = 1'b0;
        check("p64_hs_ready", ready64, 1);
        check("p64_hs_len", msglen64, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pjw_stream_hash.md
PJW_STREAM_HASH -- requirements
Module: pjw_stream_hash

Interface
REQ-001 SHALL have parameter BYTES_PER_WORD, default 4, giving the bytes per input word (legal 1..8).
REQ-002 SHALL have parameter HASH_W, default 32, giving the hash width (legal: multiple of 8, 16..64).
REQ-003 SHALL have parameter LEN_W, default 16, giving the width of the message byte counter.
REQ-004 SHALL use a single clock and a synchronous, active-high reset, with ports as follows (clock and reset first):
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset: synchronous, active-high
- Valid  in  1  input word valid
- Ready  out  1  block can accept an input word
- DataIn  in  8*BYTES_PER_WORD  input word; byte lane BYTES_PER_WORD-1 (MSBs) is hashed first
- Keep  in  BYTES_PER_WORD  per-lane enable; a lane with Keep=0 is skipped
- Last  in  1  word is the final word of the message
- Clear  in  1  abort the message and discard the accumulator
- OutValid  out  1  DataOut/MsgLen valid
- OutReady  in  1  downstream accepts the result
- DataOut  out  HASH_W  final PJW hash
- MsgLen  out  LEN_W  count of kept bytes in the message, saturating

Function
REQ-005 SHALL implement a three-state FSM: IDLE, HASH, OUT.
REQ-006 Ready SHALL be 1 only in IDLE; OutValid SHALL be 1 only in OUT.
REQ-007 In IDLE, when Valid && Ready are sampled high, the block SHALL:
- register DataIn, Keep and Last;
- set the lane index to BYTES_PER_WORD-1;
- go to HASH.
REQ-008 HASH SHALL spend exactly one cycle per lane, from lane BYTES_PER_WORD-1 down to lane 0. A skipped lane (Keep=0) SHALL still take its cycle but leave the accumulator and counter unchanged.
REQ-009 Per kept lane with byte b, with E = HASH_W/8 and h = HASH_W-bit accumulator, the update SHALL be:
- h = (h << E) + b, truncated to HASH_W bits;
- x = h AND (top E bits set);
- if x != 0, h = h XOR (x >> (3*HASH_W/4));
- h = h AND NOT x.
REQ-010 Each kept lane SHALL increment MsgLen by 1, saturating at 2^LEN_W-1.
REQ-011 After lane 0, the FSM SHALL go to OUT if the registered Last=1, else to IDLE with the accumulator retained.
REQ-012 Latency: for a word accepted at cycle edge T, Ready (or OutValid) SHALL assert in cycle T+BYTES_PER_WORD+1. Throughput SHALL be one word per BYTES_PER_WORD+1 cycles.
REQ-013 On entry to OUT, DataOut SHALL be loaded with the accumulator and MsgLen SHALL be presented. Both SHALL be held stable while OutValid=1 and OutReady=0.
REQ-014 When OutValid && OutReady, the block SHALL:
- go to IDLE the next cycle;
- clear the accumulator and the counter to 0;
- keep DataOut at its last value.
REQ-015 A Last word with Keep all zero SHALL complete the message. An empty message SHALL yield DataOut=0, MsgLen=0.
REQ-016 Clear=1 in IDLE or HASH SHALL, on the next cycle:
- zero the accumulator and the counter;
- abort the current word;
- enter IDLE.
Clear SHALL have priority over Valid acceptance.
REQ-017 Clear SHALL be ignored in OUT, so a completed result is never lost.
REQ-018 Valid, DataIn, Keep and Last SHALL be ignored outside IDLE.

Reset
REQ-019 While rst=1, the block SHALL set:
- FSM = IDLE;
- accumulator = 0, counter = 0, lane index = 0;
- Ready=1, OutValid=0, DataOut=0, MsgLen=0.
REQ-020 rst SHALL take priority over all inputs. rst asserted mid-HASH or in OUT SHALL discard the message with no output transfer.

Verification (defaults BYTES_PER_WORD=4, HASH_W=32)
REQ-021 Single word: DataIn=0x00000041, Keep=1111, Last=1 -> OutValid at T+5, DataOut=0x00000041, MsgLen=4.
REQ-022 Multi-word with fold: word 1 = 0xFFFFFFFF, Keep=1111, Last=0; word 2 = 0xFFFFFF00, Keep=1110, Last=1 -> DataOut=0x000000FF, MsgLen=7. Ready is high for one or more cycles between the two words.
REQ-023 Skipped lanes: DataIn=0x41004200, Keep=1010, Last=1 -> DataOut=0x00000452, MsgLen=2, latency still 5 cycles.
REQ-024 Backpressure and empty message:
- OutReady held 0 for 6 cycles -> DataOut and MsgLen stable, Ready=0 throughout.
- Then Keep=0000, Last=1 -> DataOut=0x00000000, MsgLen=0.
REQ-025 Clear and reset:
- Clear pulsed during the second HASH cycle, then 0x00000041 with Last=1 sent -> DataOut=0x00000041, MsgLen=4.
- rst pulsed mid-HASH -> next cycle Ready=1, OutValid=0, MsgLen=0.
REQ-026 Parameter sweep: BYTES_PER_WORD=1 and HASH_W=64, byte stream 0x41,0x42 -> DataOut=0x0000000000004142, MsgLen=2.
